// File: rtl/div_sequencer_if.sv
// Request/response bundle between a requester and the iterative divider.
// Latency: none, wiring only.
// Backpressure: request side is valid/ready; result side is valid/ready.
//   master modport: requester drives in_valid, funct3, op_w, A, B, flush, out_ready
//   slave modport : divider drives in_ready, out_valid, Y, busy
interface div_sequencer_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic            op_w;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Y;
    logic            busy;

    modport master (
        output in_valid, funct3, op_w, A, B, flush, out_ready,
        input  in_ready, out_valid, Y, busy
    );

    modport slave (
        input  in_valid, funct3, op_w, A, B, flush, out_ready,
        output in_ready, out_valid, Y, busy
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider/remainder unit (DIV/DIVU/REM/REMU and word forms).
// Latency: N+1 edges after accept (N=64, or 32 for word ops); divide-by-zero,
//   signed overflow and invalid ops complete 1 edge after accept.
// Backpressure: in_ready only in IDLE without flush; result held until out_ready.
//   Ports: clk, reset (async, active-high), bus (div_sequencer_if.slave).
module div_sequencer #(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           reset,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo;      // dividend shifts out the top, quotient bits shift in
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;      // divisor magnitude
    logic            rem_op;
    logic            word_op;
    logic            q_neg;
    logic            r_neg;
    logic            bypass;   // quo already holds the final Y (special cases)
    logic            out_valid_q;
    logic [XLEN-1:0] y_q;

    assign bus.in_ready  = (state == IDLE) && !bus.flush;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.Y         = y_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Operand decode at the request boundary
    logic            uns;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] a_res;    // dividend as it would appear in Y
    logic [XLEN-1:0] min_neg;
    logic [XLEN-1:0] special;

    always_comb begin
        uns = bus.funct3[0];
        if (bus.op_w) begin
            a_ext   = uns ? {{(XLEN-32){1'b0}}, bus.A[31:0]} : sext32(bus.A[31:0]);
            b_ext   = uns ? {{(XLEN-32){1'b0}}, bus.B[31:0]} : sext32(bus.B[31:0]);
            a_res   = sext32(bus.A[31:0]);
            min_neg = sext32(32'h8000_0000);
        end else begin
            a_ext   = bus.A;
            b_ext   = bus.B;
            a_res   = bus.A;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg    = !uns && a_ext[XLEN-1];
        b_neg    = !uns && b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = !uns && (a_ext == min_neg) && (b_ext == {XLEN{1'b1}});

        special = '0;
        if (!bus.funct3[2]) begin
            special = '0;
        end else if (div_zero) begin
            special = bus.funct3[1] ? a_res : {XLEN{1'b1}};
        end else if (ovf) begin
            special = bus.funct3[1] ? '0 : a_res;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] rem_next;

    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        fits     = (shifted >= {1'b0, dvs});
        rem_next = fits ? (shifted[XLEN-1:0] - dvs) : shifted[XLEN-1:0];
    end

    // Sign correction and word-result sign extension
    logic [XLEN-1:0] res;

    always_comb begin
        res = rem_op ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
        if (word_op) begin
            res = sext32(res[31:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            rem_op      <= 1'b0;
            word_op     <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            bypass      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else if (bus.flush) begin
            state       <= IDLE;
            count       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rem_op  <= bus.funct3[1];
                        word_op <= bus.op_w;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        dvs     <= b_mag;
                        rem     <= '0;
                        state   <= CALC;
                        if (!bus.funct3[2] || div_zero || ovf) begin
                            // Zero iterations: the next edge just publishes the value
                            bypass <= 1'b1;
                            quo    <= special;
                            count  <= '0;
                        end else begin
                            bypass <= 1'b0;
                            // Word dividends start at the top so the MSB-first
                            // loop needs only 32 steps
                            quo    <= bus.op_w ? (a_mag << (XLEN-32)) : a_mag;
                            count  <= bus.op_w ? CW'(32) : CW'(XLEN);
                        end
                    end
                end
                CALC: begin
                    if (count != '0) begin
                        rem   <= rem_next;
                        quo   <= {quo[XLEN-2:0], fits};
                        count <= count - 1'b1;
                    end else begin
                        y_q         <= bypass ? quo : res;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases, flush/reset
// aborts, output hold under backpressure, and randomized ops against an
// arithmetic reference model.
module tb_div_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div_sequencer_if #(.XLEN(64)) bus ();

    div_sequencer #(.XLEN(64)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics written with plain arithmetic
    function automatic void model(input logic [2:0] f, input logic w,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] y, output int lat);
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] r32;
        a32 = a[31:0];
        b32 = b[31:0];
        r32 = '0;
        y   = '0;
        lat = w ? 33 : 65;
        if (!f[2]) begin
            y   = '0;
            lat = 1;
        end else if (w) begin
            if (b32 == 32'h0) begin
                r32 = f[1] ? a32 : 32'hFFFF_FFFF;
                lat = 1;
            end else if (!f[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                r32 = f[1] ? 32'h0 : a32;
                lat = 1;
            end else if (f[0]) begin
                if (f[1]) r32 = a32 % b32;
                else      r32 = a32 / b32;
            end else begin
                if (f[1]) r32 = $signed(a32) % $signed(b32);
                else      r32 = $signed(a32) / $signed(b32);
            end
            y = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'h0) begin
                y   = f[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
                lat = 1;
            end else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                y   = f[1] ? 64'h0 : a;
                lat = 1;
            end else if (f[0]) begin
                if (f[1]) y = a % b;
                else      y = a / b;
            end else begin
                if (f[1]) y = $signed(a) % $signed(b);
                else      y = $signed(a) / $signed(b);
            end
        end
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {$urandom, 32'h8000_0000};
            4:       return 64'($urandom_range(1, 1000));
            5:       return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Present a request at a negedge; returns #1 after the accepting edge
    task automatic accept(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.funct3   = f;
        bus.op_w     = w;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ey, input int el, input int hold);
        int lat;
        accept(tag, f, w, a, b);
        // Inputs after the accept edge must not influence the result
        bus.funct3 = 3'($urandom);
        bus.op_w   = 1'($urandom);
        bus.A      = {$urandom, $urandom};
        bus.B      = {$urandom, $urandom};
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_y"}, bus.Y, ey);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_v"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_y"}, bus.Y, ey);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_drain_v"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_drain_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_keep_y"}, bus.Y, ey);
    endtask

    task automatic no_result(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  f;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] ey;
        int          el;

        bus.in_valid  = 1'b0;
        bus.funct3    = 3'b000;
        bus.op_w      = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_y", bus.Y, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed cases with hand-derived expected values
        do_op("divu_100_7",  3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
        do_op("remu_100_7",  3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65, 5);
        do_op("div_m7_2",    3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1);
        do_op("rem_m7_2",    3'b110, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        do_op("div_by0",     3'b100, 1'b0, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2);
        do_op("remu_by0",    3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, 0);
        do_op("div_ovf",     3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1, 0);
        do_op("rem_ovf",     3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h0, 1, 0);
        do_op("divw_ovf",    3'b100, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1, 0);
        do_op("divuw_ffff",  3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
              64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        do_op("invalid_op",  3'b011, 1'b0, 64'd100, 64'd7, 64'h0, 1, 0);

        // Flush 10 cycles into CALC, racing a new request
        accept("flush_calc", 3'b101, 1'b0, 64'd1000, 64'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.funct3   = 3'b101;
        bus.A        = 64'd5;
        bus.B        = 64'd1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_in_ready_after", 64'(bus.in_ready), 64'd1);
        no_result("flush_no_result", 80);

        // Flush beats out_ready in DONE; Y keeps its value afterwards
        accept("flush_done", 3'b100, 1'b0, 64'd9, 64'd0);
        @(posedge clk);
        #1;
        chk("flush_done_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_done_drop", 64'(bus.out_valid), 64'd0);
        chk("flush_done_busy", 64'(bus.busy), 64'd0);
        chk("flush_done_keep_y", bus.Y, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset mid-CALC takes effect between clock edges
        accept("rst_calc", 3'b101, 1'b0, 64'd100, 64'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_calc_y", bus.Y, 64'd0);
        chk("rst_calc_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_calc_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_calc_in_ready", 64'(bus.in_ready), 64'd1);
        no_result("rst_calc_no_result", 80);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) != 0) f[2] = 1'b1;
            w = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            model(f, w, a, b, ey, el);
            do_op($sformatf("rnd%0d", i), f, w, a, b, ey, el, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; all other requirements assume 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request can be accepted this cycle.
REQ-006 SHALL have port funct3  input  3  op: 100 DIV, 101 DIVU, 110 REM, 111 REMU (bit1 = remainder, bit0 = unsigned).
REQ-007 SHALL have port op_w  input  1  word op (DIVW/DIVUW/REMW/REMUW): use A[31:0], B[31:0].
REQ-008 SHALL have port A  input  64  dividend.
REQ-009 SHALL have port B  input  64  divisor.
REQ-010 SHALL have port flush  input  1  abort any in-flight op.
REQ-011 SHALL have port out_valid  output  1  Y holds a completed result.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port Y  output  64  registered result.
REQ-014 SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) && !flush; accept means in_valid && in_ready at a rising edge.
REQ-017 SHALL latch funct3, op_w, operand magnitudes and result signs on accept; later input changes have no effect.
REQ-018 SHALL, on accept of a normal op, enter CALC with iteration count N = 64 (op_w=0) or 32 (op_w=1).
REQ-019 SHALL perform radix-2 restoring division on unsigned magnitudes, one quotient bit per CALC cycle, MSB first.
REQ-020 SHALL, on the last CALC cycle, apply sign correction, register Y and enter DONE: out_valid rises exactly N+1 edges after the accept edge.
REQ-021 SHALL apply signed-op signs: quotient negative iff dividend and divisor signs differ; remainder takes the dividend's sign.
REQ-022 SHALL, for op_w=1, use signed or unsigned 32-bit operands per funct3[0] and sign-extend bit 31 of the 32-bit result into Y[63:32] (including unsigned word ops).
REQ-023 SHALL handle divisor zero without CALC: quotient = all ones (word ops: sign-extended 0xFFFFFFFF); remainder = dividend (word ops: sign-extended low word); Y valid one edge after accept.
REQ-024 SHALL handle signed overflow (most negative value / -1 at the op width) without CALC: quotient = dividend, remainder = 0; Y valid one edge after accept.
REQ-025 SHALL treat funct3[2]=0 as invalid: accept, Y=0, valid one edge after accept.
REQ-026 SHALL hold out_valid and Y stable in DONE until out_ready is high at an edge, then return to IDLE; no new request is accepted in that same cycle.
REQ-027 SHALL, on flush high at an edge in any state, go to IDLE and drop out_valid; any in-flight result is discarded.
REQ-028 SHALL give flush priority over a simultaneous in_valid (no accept) and over out_ready in DONE (result dropped).
REQ-029 SHALL keep Y at its last value outside DONE; only out_valid qualifies it.
REQ-030 SHALL drive busy = (state != IDLE).

Reset
REQ-031 SHALL, while reset is high and independent of clk, force state=IDLE, out_valid=0, Y=0, busy=0, and clear the iteration counter and working registers.
REQ-032 SHALL treat reset mid-CALC or mid-DONE as an abort, with no result produced.
REQ-033 SHALL drive in_ready=1 in the first cycle after reset deasserts if flush is low.

Verification
REQ-034 SHALL cover: DIVU A=100, B=7 accepted at edge k -> out_valid at edge k+65, Y=14; REMU same operands -> Y=2.
REQ-035 SHALL cover: DIV A=-7, B=2 -> Y=0xFFFF_FFFF_FFFF_FFFD; REM A=-7, B=2 -> Y=0xFFFF_FFFF_FFFF_FFFF.
REQ-036 SHALL cover: DIV B=0 -> Y=0xFFFF_FFFF_FFFF_FFFF at k+1; REMU A=0x1234, B=0 -> Y=0x1234 at k+1.
REQ-037 SHALL cover: DIV A=0x8000_0000_0000_0000, B=-1 -> Y=A at k+1; REM same operands -> Y=0. DIVW with low words A=0x8000_0000, B=0xFFFF_FFFF -> Y=0xFFFF_FFFF_8000_0000.
REQ-038 SHALL cover: DIVUW A=0xFFFF_FFFF, B=1 -> out_valid at k+33, Y=0xFFFF_FFFF_FFFF_FFFF.
REQ-039 SHALL cover: flush 10 cycles into CALC -> IDLE next edge, out_valid never rises; out_ready held low 5 cycles in DONE -> Y and out_valid stable throughout; reset asserted mid-CALC -> all outputs at reset values immediately, without waiting for a clk edge.
